// File: rtl/fc_layer_seq_if.sv
// Streaming handshake bundle for fc_layer_seq: activation/weight beats in, neuron results out.
interface fc_layer_seq_if #(
   parameter int NUM_OUT   = 30,
   parameter int dataWidth = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [dataWidth-1:0] in_data;
   logic [NUM_OUT-1:0]   w_col;
   logic                 out_valid;
   logic                 out_ready;
   logic [dataWidth-1:0] out_data [NUM_OUT];

   modport master (output in_valid, in_data, w_col, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, w_col, out_ready,
                   output in_ready, out_valid, out_data);
endinterface

// File: rtl/fc_layer_seq.sv
// Time-multiplexed binary-weight fully connected layer: one activation per beat,
// NUM_OUT parallel signed accumulators, bias + saturating activation on the last beat.
module fc_layer_seq_neuron #(
   parameter int DW    = 8,
   parameter int ACC_W = 20
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          beat,
   input  logic          last,
   input  logic          w,
   input  logic          bias,
   input  logic          act_mode,
   input  logic [DW-1:0] in_data,
   output logic [DW-1:0] res
);
   localparam logic signed [ACC_W-1:0] ONE  = ACC_W'(1);
   localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((1 << DW) - 1);
   localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DW - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;

   logic signed [ACC_W-1:0] acc, term, nxt, sum;
   logic [DW-1:0]           sat;

   // sum folds the final beat and the bias in so the result registers on the last edge
   always_comb begin
      term = {{(ACC_W-DW){1'b0}}, in_data};
      if (!w) term = -term;
      nxt = acc + term;
      sum = bias ? nxt + ONE : nxt - ONE;
      sat = '0;
      if (act_mode) begin
         if (sum > SMAX)      sat = SMAX[DW-1:0];
         else if (sum < SMIN) sat = SMIN[DW-1:0];
         else                 sat = sum[DW-1:0];
      end else begin
         if (sum[ACC_W-1])    sat = '0;
         else if (sum > UMAX) sat = '1;
         else                 sat = sum[DW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         res <= '0;
      end else begin
         if (clr)       acc <= '0;
         else if (beat) acc <= nxt;
         if (last)      res <= sat;
      end
   end
endmodule

module fc_layer_seq #(
   parameter int NUM_IN    = 784,
   parameter int NUM_OUT   = 30,
   parameter int dataWidth = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic [NUM_OUT-1:0]        biases,
   input  logic                      act_mode,
   output logic [$clog2(NUM_IN)-1:0] beat_cnt,
   fc_layer_seq_if.slave             bus
);
   localparam int CW    = $clog2(NUM_IN);
   localparam int ACC_W = dataWidth + CW + 2;

   typedef enum logic {ACCUM, RESULT} state_t;

   state_t               state;
   logic                 in_rdy, out_vld;
   logic                 beat, last, acc_clr;
   logic [dataWidth-1:0] res [NUM_OUT];

   // clear wins over a coincident beat; it only acts while accumulating
   assign beat    = bus.in_valid & in_rdy & ~clear;
   assign last    = beat & (beat_cnt == CW'(NUM_IN - 1));
   assign acc_clr = last | (clear & in_rdy);

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = out_vld;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ACCUM;
         in_rdy   <= 1'b1;
         out_vld  <= 1'b0;
         beat_cnt <= '0;
      end else begin
         case (state)
            ACCUM: begin
               if (clear) begin
                  beat_cnt <= '0;
               end else if (last) begin
                  beat_cnt <= '0;
                  state    <= RESULT;
                  in_rdy   <= 1'b0;
                  out_vld  <= 1'b1;
               end else if (beat) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            RESULT: begin
               if (bus.out_ready) begin
                  state   <= ACCUM;
                  in_rdy  <= 1'b1;
                  out_vld <= 1'b0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   for (genvar j = 0; j < NUM_OUT; j++) begin : g_neuron
      fc_layer_seq_neuron #(.DW(dataWidth), .ACC_W(ACC_W)) u_neuron (
         .clk      (clk),
         .rst      (rst),
         .clr      (acc_clr),
         .beat     (beat),
         .last     (last),
         .w        (bus.w_col[j]),
         .bias     (biases[j]),
         .act_mode (act_mode),
         .in_data  (bus.in_data),
         .res      (res[j])
      );
      assign bus.out_data[j] = res[j];
   end
endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed + random scoreboard bench for fc_layer_seq (small 4x2 instance and full 784x30 instance).
module tb_fc_layer_seq;
   localparam int NI = 4, NO = 2, DW = 8;
   localparam int BNI = 784, BNO = 30, BFR = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic                      clear_s, act_s, clear_b, act_b;
   logic [NO-1:0]             bias_s;
   logic [BNO-1:0]            bias_b;
   logic [$clog2(NI)-1:0]     bc_s;
   logic [$clog2(BNI)-1:0]    bc_b;

   fc_layer_seq_if #(.NUM_OUT(NO),  .dataWidth(DW)) bs ();
   fc_layer_seq_if #(.NUM_OUT(BNO), .dataWidth(DW)) bb ();

   fc_layer_seq #(.NUM_IN(NI), .NUM_OUT(NO), .dataWidth(DW)) dut_s (
      .clk(clk), .rst(rst), .clear(clear_s), .biases(bias_s), .act_mode(act_s),
      .beat_cnt(bc_s), .bus(bs.slave));
   fc_layer_seq #(.NUM_IN(BNI), .NUM_OUT(BNO), .dataWidth(DW)) dut_b (
      .clk(clk), .rst(rst), .clear(clear_b), .biases(bias_b), .act_mode(act_b),
      .beat_cnt(bc_b), .bus(bb.slave));

   int tests = 0, fails = 0;
   logic [NO*DW-1:0]  q_s [$];
   logic [BNO*DW-1:0] q_b [$];

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] sat(input int s, input logic m);
      int umax, smax, smin;
      umax = (1 << DW) - 1;
      smax = (1 << (DW - 1)) - 1;
      smin = -(1 << (DW - 1));
      if (!m) return (s < 0) ? '0 : (s > umax) ? DW'(umax) : DW'(s);
      return (s > smax) ? DW'(smax) : (s < smin) ? DW'(smin) : DW'(s);
   endfunction

   function automatic logic [NO*DW-1:0] pk_s();
      logic [NO*DW-1:0] r;
      for (int j = 0; j < NO; j++) r[j*DW +: DW] = bs.out_data[j];
      return r;
   endfunction

   function automatic logic [BNO*DW-1:0] pk_b();
      logic [BNO*DW-1:0] r;
      for (int j = 0; j < BNO; j++) r[j*DW +: DW] = bb.out_data[j];
      return r;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive_beat_s(input logic [DW-1:0] d, input logic [NO-1:0] w);
      int n;
      bs.in_valid = 1'b1; bs.in_data = d; bs.w_col = w;
      n = 0;
      while (!bs.in_ready && n < 20) begin step(); n++; end
      chk("s_beat_ready", bs.in_ready, 1'b1);
      step();
      bs.in_valid = 1'b0;
   endtask

   task automatic send_small(input logic [NI*DW-1:0] d, input logic [NI*NO-1:0] w,
                             output logic [NO*DW-1:0] e);
      int s [NO];
      logic [DW-1:0] di;
      logic [NO-1:0] wi;
      for (int j = 0; j < NO; j++) s[j] = bias_s[j] ? 1 : -1;
      for (int i = 0; i < NI; i++) begin
         di = d[i*DW +: DW];
         wi = w[i*NO +: NO];
         for (int j = 0; j < NO; j++) s[j] += wi[j] ? int'(di) : -int'(di);
         drive_beat_s(di, wi);
      end
      for (int j = 0; j < NO; j++) e[j*DW +: DW] = sat(s[j], act_s);
   endtask

   // called #1 after the last-beat edge: result must already be valid
   task automatic pop_s(input string tag);
      chk({tag, "_valid"}, bs.out_valid, 1'b1);
      chk({tag, "_data"}, pk_s(), q_s.pop_front());
   endtask

   task automatic ack_s(input string tag);
      step();
      chk({tag, "_vld_low"}, bs.out_valid, 1'b0);
      chk({tag, "_rdy_high"}, bs.in_ready, 1'b1);
   endtask

   localparam logic [NI*DW-1:0] D1   = {8'd40, 8'd30, 8'd20, 8'd10};
   localparam logic [NI*NO-1:0] W1   = {2'b01, 2'b11, 2'b01, 2'b11};
   localparam logic [NI*DW-1:0] DSAT = {4{8'd255}};
   localparam logic [NI*NO-1:0] WSAT = {4{2'b10}};
   localparam logic [NI*DW-1:0] DONE = {4{8'd1}};
   localparam logic [NI*NO-1:0] WONE = {4{2'b11}};

   initial begin
      #2ms;
      $display("FAIL watchdog timeout tests=%0d", tests);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NO*DW-1:0]  e;
      logic [BNO*DW-1:0] eb;
      logic [DW-1:0]     di;
      logic [BNO-1:0]    wi;
      int                sb [BNO];
      int                n, last_cyc;

      rst = 1'b1; clear_s = 1'b0; clear_b = 1'b0; act_s = 1'b0; act_b = 1'b0;
      bias_s = '0; bias_b = '0;
      bs.in_valid = 1'b0; bs.in_data = '0; bs.w_col = '0; bs.out_ready = 1'b1;
      bb.in_valid = 1'b0; bb.in_data = '0; bb.w_col = '0; bb.out_ready = 1'b1;
      step(); step();
      rst = 1'b0;
      step();
      chk("rst_out_valid", bs.out_valid, 1'b0);
      chk("rst_in_ready", bs.in_ready, 1'b1);
      chk("rst_beat_cnt", bc_s, '0);
      chk("rst_out_data", pk_s(), '0);
      chk("rst_big_in_ready", bb.in_ready, 1'b1);
      chk("rst_big_out_valid", bb.out_valid, 1'b0);

      // basic frame, both activation modes
      bias_s = 2'b01; act_s = 1'b0;
      send_small(D1, W1, e); q_s.push_back(e);
      chk("s1_model_relu", e, {8'd0, 8'd101});
      pop_s("s1_relu"); ack_s("s1_relu");
      act_s = 1'b1;
      send_small(D1, W1, e); q_s.push_back(e);
      chk("s1_model_sgn", e, {8'hEB, 8'd101});
      pop_s("s1_sgn"); ack_s("s1_sgn");

      // saturation
      bias_s = 2'b10; act_s = 1'b0;
      send_small(DSAT, WSAT, e); q_s.push_back(e);
      pop_s("sat_relu"); ack_s("sat_relu");
      chk("sat_relu_const", pk_s(), {8'd255, 8'd0});
      act_s = 1'b1;
      send_small(DSAT, WSAT, e); q_s.push_back(e);
      pop_s("sat_sgn"); ack_s("sat_sgn");
      chk("sat_sgn_const", pk_s(), {8'h7F, 8'h80});

      // backpressure: result held, input blocked
      bias_s = 2'b01; act_s = 1'b0; bs.out_ready = 1'b0;
      send_small(D1, W1, e); q_s.push_back(e);
      pop_s("bp");
      for (int k = 0; k < 5; k++) begin
         bs.in_valid = (k % 2 == 0); bs.in_data = 8'd99; bs.w_col = 2'b11;
         step();
         chk("bp_valid", bs.out_valid, 1'b1);
         chk("bp_data", pk_s(), e);
         chk("bp_in_ready", bs.in_ready, 1'b0);
         chk("bp_beat_cnt", bc_s, '0);
      end
      bs.in_valid = 1'b0; bs.out_ready = 1'b1;
      ack_s("bp");
      bias_s = 2'b11;
      send_small(DONE, WONE, e); q_s.push_back(e);
      chk("ones_model", e, {8'd5, 8'd5});
      pop_s("ones"); ack_s("ones");

      // clear mid-frame with a coincident beat
      bias_s = 2'b01; act_s = 1'b0;
      drive_beat_s(8'd10, 2'b11);
      drive_beat_s(8'd20, 2'b01);
      chk("clr_cnt_before", bc_s, 2);
      bs.in_valid = 1'b1; bs.in_data = 8'd30; bs.w_col = 2'b11; clear_s = 1'b1;
      step();
      clear_s = 1'b0; bs.in_valid = 1'b0;
      chk("clr_cnt_after", bc_s, '0);
      send_small(D1, W1, e); q_s.push_back(e);
      pop_s("clr"); ack_s("clr");
      chk("clr_const", pk_s(), {8'd0, 8'd101});

      // reset while holding a result
      bs.out_ready = 1'b0;
      send_small(D1, W1, e);
      chk("rstr_pending", bs.out_valid, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rstr_out_valid", bs.out_valid, 1'b0);
      chk("rstr_out_data", pk_s(), '0);
      chk("rstr_beat_cnt", bc_s, '0);
      chk("rstr_in_ready", bs.in_ready, 1'b1);
      bs.out_ready = 1'b1;

      // back-to-back random frames at full size, in_valid and out_ready held high
      last_cyc = 0;
      bb.in_valid = 1'b1;
      for (int f = 0; f < BFR; f++) begin
         act_b  = f[0];
         bias_b = BNO'($urandom);
         for (int j = 0; j < BNO; j++) sb[j] = bias_b[j] ? 1 : -1;
         for (int i = 0; i < BNI; i++) begin
            di = DW'($urandom);
            wi = BNO'($urandom);
            for (int j = 0; j < BNO; j++) sb[j] += wi[j] ? int'(di) : -int'(di);
            bb.in_data = di; bb.w_col = wi;
            n = 0;
            while (!bb.in_ready && n < 20) begin step(); n++; end
            if (i == 0) chk("b_ready", bb.in_ready, 1'b1);
            step();
         end
         for (int j = 0; j < BNO; j++) eb[j*DW +: DW] = sat(sb[j], act_b);
         q_b.push_back(eb);
         chk("b_valid", bb.out_valid, 1'b1);
         chk("b_data", pk_b(), q_b.pop_front());
         if (f > 0) chk("b_period", cyc - last_cyc, BNI + 1);
         last_cyc = cyc;
      end
      bb.in_valid = 1'b0;
      step();
      chk("b_final_vld_low", bb.out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
